// File: rtl/vadd_float_rd_pkg.sv
// vadd_float_rd_pkg: shared state type and default geometry for the vadd_float read path
package vadd_float_rd_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam int LP_BYTES_PER_BEAT = 64;
  localparam int LP_LOG_BYTES_PER_BEAT = 6;
  localparam int LP_BURST_BYTES = 4096;
  localparam int LP_LOG_BURST_LEN = 6;
endpackage

// File: rtl/vadd_float_counter.sv
// vadd_float_counter: loadable up/down counter that never decrements below zero
module vadd_float_counter #(
  parameter int C_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               incr,
  input  logic               decr,
  input  logic [C_WIDTH-1:0] load_value,
  output logic [C_WIDTH-1:0] count,
  output logic               is_zero
);
  logic dec;
  assign is_zero = count == '0;
  assign dec = decr & ~is_zero;
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (load) count <= load_value;
    else if (incr & ~dec) count <= count + 1'b1;
    else if (dec & ~incr) count <= count - 1'b1;
  end
endmodule

// File: rtl/vadd_float_rd_burst_ctrl.sv
// vadd_float_rd_burst_ctrl: splits a read command into AXI4 AR bursts with an outstanding-burst limit
module vadd_float_rd_burst_ctrl
  import vadd_float_rd_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 64,
  parameter int C_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BURST_LEN = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  input  logic                         m_axi_rvalid,
  input  logic                         m_axi_rready,
  input  logic                         m_axi_rlast
);
  localparam int W = C_XFER_SIZE_WIDTH;
  localparam int BEAT_B = C_DATA_WIDTH / 8;
  localparam int LOG_BEAT = $clog2(BEAT_B);
  localparam int LOG_LEN = $clog2(C_BURST_LEN);
  localparam int OW = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [C_ADDR_WIDTH-1:0] BURST_STEP = C_ADDR_WIDTH'(BEAT_B * C_BURST_LEN);
  localparam logic [OW-1:0] MAX_OUT = OW'(C_MAX_OUTSTANDING);
  localparam logic [7:0] FULL_LEN = 8'(C_BURST_LEN - 1);
  localparam logic [W-1:0] LEN_MASK = W'(C_BURST_LEN - 1);
  state_t state, state_n;
  logic [W-1:0] beats, bursts, rem;
  logic [7:0] last_len;
  logic [OW-1:0] outst;
  logic out_zero, rem_zero, accept, ar_hs, r_hs, drained;
  assign beats = (ctrl_xfer_size_in_bytes >> LOG_BEAT) + W'(|ctrl_xfer_size_in_bytes[LOG_BEAT-1:0]);
  assign bursts = (beats >> LOG_LEN) + W'(|beats[LOG_LEN-1:0]);
  assign accept = state == IDLE && ctrl_start && |ctrl_xfer_size_in_bytes;
  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign r_hs = m_axi_rvalid & m_axi_rready & m_axi_rlast & (state != IDLE);
  assign drained = out_zero | (outst == OW'(1) && r_hs);
  assign m_axi_arvalid = state == ISSUE && outst != MAX_OUT;
  assign m_axi_arlen = rem == W'(1) ? last_len : (rem_zero ? 8'd0 : FULL_LEN);
  assign ctrl_busy = state == ISSUE || state == DRAIN;
  assign ctrl_done = state == DONE;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = ctrl_start ? (|ctrl_xfer_size_in_bytes ? ISSUE : DONE) : IDLE;
      ISSUE:   state_n = (ar_hs && rem == W'(1)) ? DRAIN : ISSUE;
      DRAIN:   state_n = drained ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m_axi_araddr <= '0;
      last_len <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        m_axi_araddr <= ctrl_addr_offset;
        last_len <= 8'((beats - 1'b1) & LEN_MASK);
      end else if (ar_hs) begin
        m_axi_araddr <= m_axi_araddr + BURST_STEP;
      end
    end
  end
  vadd_float_counter #(.C_WIDTH(OW)) u_outstanding (
    .clk(clk), .rst(rst), .load(1'b0), .incr(ar_hs), .decr(r_hs),
    .load_value('0), .count(outst), .is_zero(out_zero)
  );
  vadd_float_counter #(.C_WIDTH(W)) u_remaining (
    .clk(clk), .rst(rst), .load(accept), .incr(1'b0), .decr(ar_hs),
    .load_value(bursts), .count(rem), .is_zero(rem_zero)
  );
endmodule

// File: tb/tb_vadd_float_rd_burst_ctrl.sv
// tb_vadd_float_rd_burst_ctrl: directed checks of burst split, stall, outstanding limit and reset
module tb_vadd_float_rd_burst_ctrl;
  logic clk = 0, rst = 1, ctrl_start = 0;
  logic [63:0] ctrl_addr_offset = '0;
  logic [31:0] ctrl_xfer_size_in_bytes = '0;
  logic ctrl_busy, ctrl_done, m_axi_arvalid, m_axi_arready = 0;
  logic [63:0] m_axi_araddr;
  logic [7:0] m_axi_arlen;
  logic m_axi_rvalid = 0, m_axi_rready = 0, m_axi_rlast = 0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  vadd_float_rd_burst_ctrl #(.C_MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst), .ctrl_start(ctrl_start), .ctrl_addr_offset(ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes), .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rlast(m_axi_rlast)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic ar(input string tag, input logic v, input logic [63:0] a, input logic [7:0] l);
    chk({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'(v));
    chk({tag, "_araddr"}, m_axi_araddr, a);
    chk({tag, "_arlen"}, 64'(m_axi_arlen), 64'(l));
  endtask
  task automatic st(input string tag, input logic busy, input logic done);
    chk({tag, "_busy"}, 64'(ctrl_busy), 64'(busy));
    chk({tag, "_done"}, 64'(ctrl_done), 64'(done));
  endtask
  task automatic start(input logic [63:0] off, input logic [31:0] size);
    if (off[11:0] != 12'd0) $fatal(1, "unaligned offset %0h", off);
    ctrl_addr_offset = off;
    ctrl_xfer_size_in_bytes = size;
    ctrl_start = 1;
    step();
    ctrl_start = 0;
  endtask
  task automatic rl(input logic v);
    m_axi_rvalid = v;
    m_axi_rready = v;
    m_axi_rlast = v;
  endtask
  initial begin
    step(); step();
    ar("rst", 0, 64'h0, 8'd0);
    st("rst", 0, 0);
    rst = 0;
    step();
    start(64'h1000, 0);
    st("z0", 0, 1);
    chk("z0_arvalid", 64'(m_axi_arvalid), 64'h0);
    step();
    st("z1", 0, 0);
    chk("z1_arvalid", 64'(m_axi_arvalid), 64'h0);
    rl(1);
    step();
    rl(0);
    st("stray", 0, 0);
    m_axi_arready = 1;
    start(64'h2000, 64);
    ar("s64", 1, 64'h2000, 8'd0);
    st("s64", 1, 0);
    step();
    ar("s64_post", 0, 64'h3000, 8'd0);
    st("s64_drain", 1, 0);
    rl(1);
    step();
    rl(0);
    st("s64_done", 0, 1);
    step();
    st("s64_idle", 0, 0);
    m_axi_arready = 0;
    start(64'h10000, 12416);
    ar("b0", 1, 64'h10000, 8'd63);
    for (int i = 0; i < 10; i++) begin
      step();
      ar("stall", 1, 64'h10000, 8'd63);
    end
    m_axi_arready = 1;
    step();
    ar("b1", 1, 64'h11000, 8'd63);
    step();
    ar("full", 0, 64'h12000, 8'd63);
    ctrl_xfer_size_in_bytes = 64;
    ctrl_addr_offset = 64'h5000;
    ctrl_start = 1;
    step();
    ctrl_start = 0;
    ar("busy_start", 0, 64'h12000, 8'd63);
    st("busy_start", 1, 0);
    rl(1);
    step();
    rl(0);
    ar("b2", 1, 64'h12000, 8'd63);
    step();
    ar("full2", 0, 64'h13000, 8'd1);
    rl(1);
    step();
    ar("b3", 1, 64'h13000, 8'd1);
    step();
    rl(0);
    chk("coinc_arvalid", 64'(m_axi_arvalid), 64'h0);
    st("coinc", 1, 0);
    step();
    st("drain_wait", 1, 0);
    rl(1);
    step();
    rl(0);
    st("b_done", 0, 1);
    step();
    st("b_idle", 0, 0);
    start(64'h20000, 100);
    ar("s100", 1, 64'h20000, 8'd1);
    step();
    chk("s100_post", 64'(m_axi_arvalid), 64'h0);
    rl(1);
    step();
    rl(0);
    st("s100_done", 0, 1);
    step();
    start(64'h30000, 5 * 4096);
    ar("r0", 1, 64'h30000, 8'd63);
    step();
    ar("r1", 1, 64'h31000, 8'd63);
    rst = 1;
    m_axi_arready = 0;
    step();
    rst = 0;
    ar("mid_rst", 0, 64'h0, 8'd0);
    st("mid_rst", 0, 0);
    step();
    st("post_rst", 0, 0);
    start(64'h40000, 64);
    ar("rs64", 1, 64'h40000, 8'd0);
    m_axi_arready = 1;
    step();
    chk("rs64_post", 64'(m_axi_arvalid), 64'h0);
    st("rs64_drain", 1, 0);
    rl(1);
    step();
    rl(0);
    st("rs64_done", 0, 1);
    step();
    st("rs64_idle", 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
